// File: rtl/divider_unit_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// iteration-counter width and the control FSM state encoding.
package divider_unit_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CW        = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/divider_unit_step.sv
// One restoring-division step: shifts {p,a} left by one, trial-subtracts d
// from the upper half and sets the new quotient bit in a[0].
module divider_unit_step
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] p_next,
  output logic [WIDTH-1:0] a_next
);

  // Two extra bits: one for the bit shifted out of p, one for the sign, so a
  // divisor with its MSB set still compares correctly.
  logic signed [WIDTH+1:0] diff;
  logic                    unused_diff_bit;

  always_comb begin
    diff = $signed({1'b0, p, a[WIDTH-1]}) - $signed({2'b00, d});
    if (!diff[WIDTH+1]) begin
      p_next = diff[WIDTH-1:0];
      a_next = {a[WIDTH-2:0], 1'b1};
    end else begin
      p_next = {p[WIDTH-2:0], a[WIDTH-1]};
      a_next = {a[WIDTH-2:0], 1'b0};
    end
  end

  // The partial remainder never exceeds the divisor, so bit WIDTH of a
  // successful difference is always zero.
  assign unused_diff_bit = diff[WIDTH];

endmodule

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider producing one quotient bit per clock;
// a start pulse loads operands, ready flags a completed QO/RO pair.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] initCounter,
  input  logic             enable,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] QO,
  output logic [WIDTH-1:0] RO,
  output logic             ready
);

  localparam int               CNT_W   = (WIDTH == WIDTH_DEF) ? CW : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] K_MAX   = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] K_MAX_W = WIDTH'(WIDTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] k_load;
  logic             last;
  logic [WIDTH-1:0] p_reg, a_reg, d_reg;
  logic [WIDTH-1:0] p_next, a_next;

  // Iteration count is clamped to WIDTH; the dividend is left-aligned so only
  // its k low bits take part in the division.
  assign k_load = (initCounter > K_MAX_W) ? K_MAX : initCounter[CNT_W-1:0];
  assign last   = (counter <= CNT_W'(1));

  divider_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .d      (d_reg),
    .p_next (p_next),
    .a_next (a_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (enable) begin
      state_next = BUSY;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        BUSY:    if (last) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control and result registers; a start always wins over an iteration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
      ready   <= 1'b0;
      QO      <= '0;
      RO      <= '0;
    end else if (enable) begin
      counter <= k_load;
      ready   <= 1'b0;
    end else if (state == BUSY) begin
      if (counter != '0) begin
        counter <= counter - CNT_W'(1);
      end
      if (last) begin
        ready <= 1'b1;
        QO    <= (counter == '0) ? a_reg : a_next;
        RO    <= (counter == '0) ? p_reg : p_next;
      end
    end
  end

  // Working registers carry no reset; every operation reloads them on start.
  always_ff @(posedge clk) begin
    if (enable) begin
      d_reg <= D;
      p_reg <= '0;
      a_reg <= N << (K_MAX - k_load);
    end else if (state == BUSY && counter != '0) begin
      p_reg <= p_next;
      a_reg <= a_next;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed and randomised checks of divider_unit: latency, results, clamping,
// restart, hold and asynchronous reset behaviour.
module tb_divider_unit;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] init_counter;
  logic         enable;
  logic [W-1:0] n_in;
  logic [W-1:0] d_in;
  logic [W-1:0] qo;
  logic [W-1:0] ro;
  logic         ready;

  int checks;
  int failures;

  divider_unit #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .initCounter (init_counter),
    .enable      (enable),
    .N           (n_in),
    .D           (d_in),
    .QO          (qo),
    .RO          (ro),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start pulse; returns #1 after the start edge.
  task automatic start_pulse(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] k);
    n_in         = n;
    d_in         = d;
    init_counter = k;
    enable       = 1'b1;
    tick();
    enable       = 1'b0;
  endtask

  // Runs one operation with latency lat edges and checks ready timing and results.
  task automatic run_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [W-1:0] k, input int lat,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r);
    logic early;
    start_pulse(n, d, k);
    early = (ready !== 1'b0);
    for (int i = 1; i < lat; i++) begin
      tick();
      if (ready !== 1'b0) early = 1'b1;
    end
    chk({tag, "_early"}, W'(early), W'(0));
    tick();
    chk({tag, "_ready"}, W'(ready), W'(1));
    chk({tag, "_q"}, qo, exp_q);
    chk({tag, "_r"}, ro, exp_r);
  endtask

  initial begin
    logic         seen;
    logic [W-1:0] rn, rd;
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    n_in         = '0;
    d_in         = '0;
    init_counter = W'(64);
    #12;
    chk("rst_q", qo, '0);
    chk("rst_r", ro, '0);
    chk("rst_ready", W'(ready), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("basic", 64'd100, 64'd7, 64'd64, 64, 64'd14, 64'd2);
    run_op("small", 64'd5, 64'd9, 64'd64, 64, 64'd0, 64'd5);
    run_op("ones_ones", '1, '1, 64'd64, 64, 64'd1, 64'd0);
    run_op("ones_one", '1, 64'd1, 64'd64, 64, '1, 64'd0);
    run_op("div_zero", 64'd1234, 64'd0, 64'd64, 64, '1, 64'd1234);
    run_op("k8", 64'hFF_00C8, 64'd10, 64'd8, 8, 64'd20, 64'd0);
    run_op("k0", 64'd55, 64'd3, 64'd0, 1, 64'd0, 64'd0);
    run_op("kclamp", 64'd100, 64'd7, 64'd100, 64, 64'd14, 64'd2);

    repeat (5) tick();
    chk("hold_q", qo, 64'd14);
    chk("hold_r", ro, 64'd2);
    chk("hold_ready", W'(ready), W'(1));

    // Restart on the 30th edge of an operation; the aborted one never completes.
    start_pulse(64'd5000, 64'd7, 64'd64);
    seen = (ready !== 1'b0);
    repeat (28) begin
      tick();
      if (ready !== 1'b0) seen = 1'b1;
    end
    chk("abort_ready", W'(seen), W'(0));
    run_op("restart", 64'd1000, 64'd3, 64'd64, 64, 64'd333, 64'd1);

    for (int i = 0; i < 100; i++) begin
      rn = {$urandom, $urandom};
      rd = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (rd == '0) rd = 64'd1;
      run_op("rand", rn, rd, 64'd64, 64, rn / rd, rn % rd);
    end

    // Asynchronous reset mid-operation, away from any clock edge.
    start_pulse(64'd100, 64'd7, 64'd64);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q", qo, '0);
    chk("arst_r", ro, '0);
    chk("arst_ready", W'(ready), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (80) begin
      tick();
      if (ready !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_done", W'(seen), W'(0));
    chk("arst_q_hold", qo, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
